// File: rtl/crc_reader_pkg.sv
// Shared register map, control bit positions, CRC-32 constants and FSM encoding
// for the on-chip memory CRC reader.
package crc_reader_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_BASE = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CRC  = 2'd3;

  localparam int CTRL_START  = 0;  // write side
  localparam int CTRL_CLEAR  = 1;  // write side
  localparam int STAT_BUSY   = 0;  // read side
  localparam int STAT_DONE   = 1;  // read side
  localparam int STAT_ERROR  = 2;  // read side
  localparam int CTRL_IRQ_EN = 3;  // both sides

  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit-reverse a word; the reflected CRC shifts LSB-first.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_word.sv
// One-cycle reflected CRC-32 update over a 32-bit word whose bytes are taken
// little-endian (bits 7:0 first).
module crc32_word
  import crc_reader_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  always_comb begin
    // NOTE: blocking assignments here: each loop iteration must see the value the previous one produced.
    crc_out = crc_in ^ data;
    for (int i = 0; i < 32; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/onchip_mem_crc_reader.sv
// Control-slave programmable engine that streams BASE..BASE+LENGTH-1 out of an
// on-chip memory with one address per cycle and reports the CRC-32 of the words.
module onchip_mem_crc_reader
  import crc_reader_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int MEM_DEPTH = 256000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ctl_address,
  input  logic              ctl_write,
  input  logic [31:0]       ctl_writedata,
  input  logic              ctl_read,
  output logic [31:0]       ctl_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              irq
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, len_q, addr_q, remain_q;
  logic [31:0]       crc_q, acc_q, acc_next;
  logic              done_q, err_q, irq_en_q, rd_valid_q;

  logic              busy, ctrl_wr, start_ok, range_err, len_zero;
  logic [ADDR_W:0]   end_addr;
  logic              unused_wdata;

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign ctrl_wr   = ctl_write && (ctl_address == REG_CTRL);
  assign start_ok  = ctrl_wr && ctl_writedata[CTRL_START] && !busy;
  // Widened by one bit so a range running past the top of memory cannot wrap.
  assign end_addr  = {1'b0, base_q} + {1'b0, len_q};
  assign range_err = end_addr > DEPTH;
  assign len_zero  = (len_q == '0);
  assign unused_wdata = ^ctl_writedata[31:ADDR_W];

  assign mem_address    = addr_q;
  assign mem_chipselect = (state_q == ST_ISSUE);
  assign mem_clken      = busy;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign irq            = done_q & irq_en_q;

  crc32_word u_crc (
    .crc_in  (acc_q),
    .data    (mem_readdata),
    .crc_out (acc_next)
  );

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; reset_n is deliberately absent from the sensitivity list.
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets its default first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok && !range_err && !len_zero) state_d = ST_ISSUE;
        else                                     state_d = ST_IDLE;
      end
      ST_ISSUE: if (remain_q == '0) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q       <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      remain_q     <= '0;
      crc_q        <= '0;
      acc_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      ctl_readdata <= '0;
    end else begin
      if (ctl_write && !busy) begin
        if (ctl_address == REG_BASE) base_q <= ctl_writedata[ADDR_W-1:0];
        if (ctl_address == REG_LEN)  len_q  <= ctl_writedata[ADDR_W-1:0];
      end
      if (ctrl_wr) begin
        irq_en_q <= ctl_writedata[CTRL_IRQ_EN];
        if (ctl_writedata[CTRL_CLEAR]) begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
      end
      // Evaluated after the clear so a combined start+clear write lets start decide done.
      if (start_ok) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        if (range_err) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else if (len_zero) begin
          done_q <= 1'b1;
          crc_q  <= '0;
        end else begin
          addr_q   <= base_q;
          remain_q <= len_q - 1'b1;
          acc_q    <= CRC_INIT;
        end
      end
      if (state_q == ST_ISSUE && remain_q != '0) begin
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
      // Read data lags its address by one cycle.
      rd_valid_q <= (state_q == ST_ISSUE);
      if (rd_valid_q) acc_q <= acc_next;
      if (state_q == ST_DRAIN) begin
        crc_q  <= acc_next ^ CRC_XOROUT;
        done_q <= 1'b1;
      end
      if (ctl_read) begin
        case (ctl_address)
          REG_CTRL: ctl_readdata <= {28'd0, irq_en_q, err_q, done_q, busy};
          REG_BASE: ctl_readdata <= 32'(base_q);
          REG_LEN:  ctl_readdata <= 32'(len_q);
          default:  ctl_readdata <= crc_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_crc_reader.sv
// Scoreboard bench: stimulus queues expected memory accesses and register reads;
// a negedge monitor pops and compares them against a byte-wise CRC-32 model.
module tb_onchip_mem_crc_reader;

  localparam int ADDR_W = 18;
  localparam int DEPTH  = 256000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        ctl_address;
  logic              ctl_write;
  logic [31:0]       ctl_writedata;
  logic              ctl_read;
  logic [31:0]       ctl_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [31:0]       mem_readdata = '0;
  logic              irq;

  onchip_mem_crc_reader #(.ADDR_W(ADDR_W), .MEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctl_address    (ctl_address),
    .ctl_write      (ctl_write),
    .ctl_writedata  (ctl_writedata),
    .ctl_read       (ctl_read),
    .ctl_readdata   (ctl_readdata),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (mem_clken) mem_readdata <= mem[mem_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; } acc_t;
  typedef struct { string name; logic [31:0] val; } rd_t;
  acc_t exp_acc[$];
  rd_t  exp_rd[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_crc = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference CRC-32: byte stream, LSB-first, reflected polynomial of 0x04C11DB7.
  function automatic logic [31:0] crc_ref(int base, int len);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = mem[base+i];
      for (int b = 0; b < 4; b++) begin
        c = c ^ {24'd0, w[8*b +: 8]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen <= ctl_read;

  always @(negedge clk) begin
    if (mem_chipselect) begin
      if (exp_acc.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_access: got address 0x%05h, required no access (cycle %0d)", mem_address, cyc);
      end else begin
        acc_t e;
        e = exp_acc.pop_front();
        check("access_addr", 32'(mem_address), e.addr);
        check("access_cycle", cyc, e.cyc);
        check("clken_with_cs", 32'(mem_clken), 32'd1);
      end
    end
    if (rd_seen) begin
      if (exp_rd.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h with no read queued", ctl_readdata);
      end else begin
        rd_t r;
        r = exp_rd.pop_front();
        check(r.name, ctl_readdata, r.val);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    ctl_address = a; ctl_writedata = d; ctl_write = 1'b1;
    @(posedge clk); #1;
    ctl_write = 1'b0;
  endtask

  task automatic rd(string nm, logic [1:0] a, logic [31:0] e);
    rd_t r;
    r.name = nm; r.val = e;
    exp_rd.push_back(r);
    ctl_address = a; ctl_read = 1'b1;
    @(posedge clk); #1;
    ctl_read = 1'b0;
  endtask

  task automatic run_scan(int base, int len, logic ie, logic clr, logic meddle);
    logic [31:0] ie_bits, new_crc;
    int t;
    acc_t a;
    ie_bits = ie ? 32'h8 : 32'h0;
    wr(2'd1, 32'(base));
    wr(2'd2, 32'(len));
    t = cyc;
    wr(2'd0, 32'h1 | ie_bits | (clr ? 32'h2 : 32'h0));
    if (base + len > DEPTH) begin
      rd("status_error", 2'd0, 32'h6 | ie_bits);
      rd("crc_unchanged", 2'd3, m_crc);
    end else if (len == 0) begin
      m_crc = '0;
      rd("status_len0", 2'd0, 32'h2 | ie_bits);
      rd("crc_len0", 2'd3, m_crc);
    end else begin
      for (int i = 0; i < len; i++) begin
        a.cyc = t + 1 + i; a.addr = base + i;
        exp_acc.push_back(a);
      end
      new_crc = crc_ref(base, len);
      rd("status_busy", 2'd0, 32'h1 | ie_bits);
      if (meddle) begin
        step(t + 5 - cyc);
        wr(2'd0, 32'h1 | ie_bits);
        wr(2'd1, 32'(base) ^ 32'h155);
        wr(2'd2, 32'(len + 3));
        rd("crc_while_busy", 2'd3, m_crc);
      end
      step(t + len + 1 - cyc);
      rd("status_drain", 2'd0, 32'h1 | ie_bits);
      @(negedge clk);
      check("clken_after_done", 32'(mem_clken), 32'd0);
      check("irq_at_done", 32'(irq), 32'(ie));
      rd("status_done", 2'd0, 32'h2 | ie_bits);
      m_crc = new_crc;
      rd("crc_result", 2'd3, m_crc);
      if (meddle) begin
        rd("base_kept", 2'd1, 32'(base));
        rd("len_kept", 2'd2, 32'(len));
      end
    end
  endtask

  initial begin
    int t, base, len;
    acc_t a;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h0;

    reset_n = 1'b0; ctl_address = '0; ctl_write = 1'b0; ctl_writedata = '0; ctl_read = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_readdata", ctl_readdata, 32'h0);
    check("rst_address", 32'(mem_address), 32'h0);
    check("rst_cs", 32'(mem_chipselect), 32'h0);
    check("rst_clken", 32'(mem_clken), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("mem_write_low", 32'(mem_write), 32'h0);
    check("byteenable_all", 32'(mem_byteenable), 32'hF);
    reset_n = 1'b1;
    step(1);
    rd("rst_status", 2'd0, 32'h0);
    rd("rst_crc", 2'd3, 32'h0);

    // Single zero word at address 0 has a well-known CRC.
    run_scan(0, 1, 1'b0, 1'b0, 1'b0);
    rd("crc_known_zero_word", 2'd3, 32'h2144DF1C);

    run_scan(0, 0, 1'b0, 1'b0, 1'b0);
    run_scan(1234, 5, 1'b0, 1'b0, 1'b0);
    run_scan(255990, 16, 1'b0, 1'b0, 1'b0);
    run_scan(255984, 16, 1'b0, 1'b1, 1'b0);
    run_scan(4096, 16, 1'b0, 1'b0, 1'b1);

    // Interrupt: raise on done, drop after clear (write 0x2 also clears irq_en).
    run_scan(77, 3, 1'b1, 1'b0, 1'b0);
    wr(2'd0, 32'h2);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);
    rd("status_after_clear", 2'd0, 32'h0);
    run_scan(300, 4, 1'b1, 1'b1, 1'b0);
    wr(2'd0, 32'hA);
    @(negedge clk);
    check("irq_cleared_keep_en", 32'(irq), 32'h0);
    rd("status_clear_keep_en", 2'd0, 32'h8);

    for (int n = 0; n < 8; n++) begin
      len  = $urandom_range(0, 24);
      base = $urandom_range(0, DEPTH - 32);
      run_scan(base, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (len >= 10) && ($urandom_range(0, 1) == 1));
    end
    for (int n = 0; n < 2; n++) begin
      base = DEPTH - $urandom_range(0, 8);
      run_scan(base, $urandom_range(9, 30), 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a 16-word scan.
    wr(2'd1, 32'd1000);
    wr(2'd2, 32'd16);
    t = cyc;
    wr(2'd0, 32'h9);
    for (int i = 0; i < 4; i++) begin
      a.cyc = t + 1 + i; a.addr = 1000 + i;
      exp_acc.push_back(a);
    end
    rd("crc_prev_before_reset", 2'd3, m_crc);
    step(t + 4 - cyc);
    reset_n = 1'b0;
    step(1);
    @(negedge clk);
    check("midrst_readdata", ctl_readdata, 32'h0);
    check("midrst_address", 32'(mem_address), 32'h0);
    check("midrst_cs", 32'(mem_chipselect), 32'h0);
    check("midrst_clken", 32'(mem_clken), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    m_crc = '0;
    step(4);
    rd("midrst_status", 2'd0, 32'h0);
    rd("midrst_crc", 2'd3, 32'h0);
    rd("midrst_base", 2'd1, 32'h0);
    rd("midrst_len", 2'd2, 32'h0);

    step(5);
    check("pending_accesses", exp_acc.size(), 32'd0);
    check("pending_reads", exp_rd.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
